// File: rtl/stream_downsizer.sv
`default_nettype none
// ============================================================================
//  Module   : stream_downsizer
//  Brief    : Serialises wide fifo words (RATIO slices of OUT_WIDTH bits,
//             valid-beat count, last flag) into a registered stream of
//             narrow beats with full throughput across back-to-back words.
//  Revision : 1.0 - initial release
// ============================================================================
module stream_downsizer #(
    parameter int OUT_WIDTH = 8,
    parameter int RATIO     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         w_valid,
    output logic                         w_ready,
    input  logic [RATIO*OUT_WIDTH-1:0]   w_data,
    input  logic [$clog2(RATIO+1)-1:0]   w_beats,
    input  logic                         w_last,
    output logic                         r_valid,
    input  logic                         r_ready,
    output logic [OUT_WIDTH-1:0]         r_data,
    output logic                         r_last
);

    localparam int                CNT_W   = $clog2(RATIO + 1);
    localparam logic [CNT_W-1:0]  c_RATIO = CNT_W'(RATIO);
    localparam logic [CNT_W-1:0]  c_ONE   = CNT_W'(1);
    // Slice emitted first after a load: bottom slice or top slice.
    localparam logic [CNT_W-1:0]  c_FIRST = MSB_FIRST ? CNT_W'(RATIO - 1) : '0;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t                       state_q, state_d;
    logic [RATIO*OUT_WIDTH-1:0]   hold_q, hold_d;
    logic                         hlast_q, hlast_d;
    logic [CNT_W-1:0]             rem_q, rem_d;
    logic [CNT_W-1:0]             idx_q, idx_d;
    logic [OUT_WIDTH-1:0]         data_q, data_d;
    logic                         rlast_q, rlast_d;

    logic                         w_hs;
    logic                         w_done;
    logic                         w_acc;
    logic [CNT_W-1:0]             w_eff;
    logic [CNT_W-1:0]             w_idx_nx;
    logic [CNT_W-1:0]             w_rem_nx;

    // Select one slice of a word by index; a mux over the legal indices keeps
    // the select free of out-of-range part-selects.
    function automatic logic [OUT_WIDTH-1:0] slice_of(
        input logic [RATIO*OUT_WIDTH-1:0] word,
        input logic [CNT_W-1:0]           idx
    );
        logic [OUT_WIDTH-1:0] s;
        s = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (idx == CNT_W'(i)) begin
                s = word[i*OUT_WIDTH +: OUT_WIDTH];
            end
        end
        return s;
    endfunction

    // Handshake decode; w_ready depends on r_ready only, never on w_valid.
    always_comb begin
        w_hs     = (state_q == S_BUSY) && r_ready;
        w_done   = w_hs && (rem_q == c_ONE);
        w_ready  = (state_q == S_IDLE) || w_done;
        w_acc    = w_valid && w_ready;
        w_eff    = ((w_beats == '0) || (w_beats > c_RATIO)) ? c_RATIO : w_beats;
        w_idx_nx = MSB_FIRST ? (idx_q - c_ONE) : (idx_q + c_ONE);
        w_rem_nx = rem_q - c_ONE;
    end

    // Next-state: load on accept, step on handshake, go idle after final beat.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        hlast_d = hlast_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        data_d  = data_q;
        rlast_d = rlast_q;
        if (w_acc) begin
            // Covers both the idle load and the no-bubble reload on the final beat.
            state_d = S_BUSY;
            hold_d  = w_data;
            hlast_d = w_last;
            rem_d   = w_eff;
            idx_d   = c_FIRST;
            data_d  = slice_of(w_data, c_FIRST);
            rlast_d = w_last && (w_eff == c_ONE);
        end else if (w_done) begin
            state_d = S_IDLE;
            rem_d   = '0;
            rlast_d = 1'b0;
        end else if (w_hs) begin
            rem_d   = w_rem_nx;
            idx_d   = w_idx_nx;
            data_d  = slice_of(hold_q, w_idx_nx);
            rlast_d = hlast_q && (w_rem_nx == c_ONE);
        end
    end

    // State and output registers; reset discards any held word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            hold_q  <= '0;
            hlast_q <= 1'b0;
            rem_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            rlast_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            hlast_q <= hlast_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            rlast_q <= rlast_d;
        end
    end

    assign r_valid = (state_q == S_BUSY);
    assign r_data  = data_q;
    assign r_last  = rlast_q;

endmodule
`default_nettype wire
